// File: rtl/tlb_miss_ctrl_pkg.sv
// Shared constants, FSM state type and match-line helpers for the TLB miss controller.
package tlb_pkg;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [ENTRIES-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // True when more than one bit is set (clearing the lowest set bit leaves something).
  function automatic logic more_than_one(input logic [ENTRIES-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

  function automatic logic [ENTRIES-1:0] idx_onehot(input logic [IDX_W-1:0] i);
    return ENTRIES'(1) << i;
  endfunction

endpackage

// File: rtl/tlb_miss_ctrl_if.sv
// Lookup, refill and CAM-write signals of the TLB miss controller, plus its debug state.
interface tlb_miss_ctrl_if
  import tlb_pkg::*;
#(
  parameter int DATA_SIZE = 19
);

  logic                 lookup_valid;
  logic [DATA_SIZE-1:0] lookup_tag;
  logic [ENTRIES-1:0]   hit;
  logic                 flush;
  logic                 hit_valid;
  logic [IDX_W-1:0]     hit_idx;
  logic                 multi_hit;
  logic                 stall;
  logic                 refill_req;
  logic [DATA_SIZE-1:0] refill_tag;
  logic                 refill_ack;
  logic                 refill_err;
  logic                 fault;
  logic [ENTRIES-1:0]   cam_we;
  logic [DATA_SIZE-1:0] cam_wdata;
  state_t               state;

  // Handshake: refill_req rises the cycle after a miss and holds with a stable refill_tag
  // until the cycle refill_ack is high (transfer happens in that cycle); refill_err only
  // has meaning in the ack cycle. stall stays high from the miss cycle until back in IDLE.
  modport master (
    output lookup_valid, lookup_tag, hit, flush, refill_ack, refill_err,
    input  hit_valid, hit_idx, multi_hit, stall, refill_req, refill_tag,
           fault, cam_we, cam_wdata, state
  );

  modport slave (
    input  lookup_valid, lookup_tag, hit, flush, refill_ack, refill_err,
    output hit_valid, hit_idx, multi_hit, stall, refill_req, refill_tag,
           fault, cam_we, cam_wdata, state
  );

endinterface

// File: rtl/tlb_miss_ctrl_plru_tree16.sv
// Replacement state for the 16-entry TLB: tree pseudo-LRU when TLB_PLRU_EN is defined,
// otherwise a round-robin pointer that only advances on allocations into a full table.
module plru_tree16
  import tlb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic             alloc,
  output logic [IDX_W-1:0] victim
);

`ifdef TLB_PLRU_EN

  logic [ENTRIES-2:0] tree_q;
  logic [ENTRIES-2:0] tree_d;
  logic [3:0]         vn1, vn2, vn3;
  logic [3:0]         tn1, tn2, tn3;
  logic               unused_alloc;

  assign unused_alloc = alloc;

  // Heap-ordered tree: node n has children 2n+1 (bit 0, left) and 2n+2 (bit 1, right).
  function automatic logic [3:0] child(input logic [3:0] n, input logic b);
    return {n[2:0], 1'b0} + 4'd1 + {3'b000, b};
  endfunction

  always_comb begin
    victim    = '0;
    victim[3] = tree_q[0];
    vn1       = child(4'd0, victim[3]);
    victim[2] = tree_q[vn1];
    vn2       = child(vn1, victim[2]);
    victim[1] = tree_q[vn2];
    vn3       = child(vn2, victim[1]);
    victim[0] = tree_q[vn3];
  end

  // A touch points every node on its path toward the opposite subtree.
  always_comb begin
    tree_d = tree_q;
    tn1    = child(4'd0, touch_idx[3]);
    tn2    = child(tn1, touch_idx[2]);
    tn3    = child(tn2, touch_idx[1]);
    if (touch_en) begin
      tree_d[0]   = ~touch_idx[3];
      tree_d[tn1] = ~touch_idx[2];
      tree_d[tn2] = ~touch_idx[1];
      tree_d[tn3] = ~touch_idx[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tree_q <= '0;
    else      tree_q <= tree_d;
  end

`else

  logic [IDX_W-1:0] ptr_q;

  // On a full-table allocation touch_idx is the pointer itself, so this is ptr + 1 mod 16.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  ptr_q <= '0;
    else if (touch_en && alloc) ptr_q <= touch_idx + 1'b1;
  end

  assign victim = ptr_q;

`endif

endmodule

// File: rtl/tlb_miss_ctrl.sv
// TLB miss controller: qualifies CAM match lines, runs the refill handshake and writes
// the refilled tag into a victim entry. Replacement policy selected by TLB_PLRU_EN.
module tlb_miss_ctrl
  import tlb_pkg::*;
#(
  parameter int DATA_SIZE = 19
) (
  input  logic            clk,
  input  logic            rst,
  tlb_miss_ctrl_if.slave  bus
);

  state_t               state_q, state_d;
  logic [ENTRIES-1:0]   valid_q;
  logic [ENTRIES-1:0]   qhit;
  logic [ENTRIES-1:0]   victim_oh;
  logic [DATA_SIZE-1:0] tag_q;
  logic                 latch_tag;
  logic                 touch_en;
  logic                 alloc;
  logic                 full;
  logic [IDX_W-1:0]     touch_idx;
  logic [IDX_W-1:0]     repl_victim;
  logic [IDX_W-1:0]     victim;

  assign qhit      = bus.hit & valid_q;
  assign full      = &valid_q;
  assign victim    = full ? repl_victim : lowest_idx(~valid_q);
  assign victim_oh = idx_onehot(victim);

  assign bus.refill_tag = tag_q;
  assign bus.state      = state_q;

  plru_tree16 u_repl (
    .clk       (clk),
    .rst       (rst),
    .touch_en  (touch_en),
    .touch_idx (touch_idx),
    .alloc     (alloc),
    .victim    (repl_victim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           tag_q <= '0;
    else if (latch_tag) tag_q <= bus.lookup_tag;
  end

  // A flush landing on the write cycle still keeps the freshly written entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    valid_q <= '0;
    else if (bus.flush)          valid_q <= (state_q == WRITE) ? victim_oh : '0;
    else if (state_q == WRITE)   valid_q <= valid_q | victim_oh;
  end

  always_comb begin
    state_d        = state_q;
    latch_tag      = 1'b0;
    touch_en       = 1'b0;
    touch_idx      = '0;
    alloc          = 1'b0;
    bus.hit_valid  = 1'b0;
    bus.hit_idx    = '0;
    bus.multi_hit  = 1'b0;
    bus.stall      = 1'b0;
    bus.refill_req = 1'b0;
    bus.fault      = 1'b0;
    bus.cam_we     = '0;
    bus.cam_wdata  = bus.lookup_tag;

    case (state_q)
      IDLE: begin
        // rst gating keeps every output low while reset is held.
        if (rst && bus.lookup_valid) begin
          if (|qhit) begin
            bus.hit_valid = 1'b1;
            bus.hit_idx   = lowest_idx(qhit);
            bus.multi_hit = more_than_one(qhit);
            touch_en      = 1'b1;
            touch_idx     = lowest_idx(qhit);
          end else begin
            bus.stall = 1'b1;
            latch_tag = 1'b1;
            state_d   = REQ;
          end
        end
      end

      REQ: begin
        bus.stall      = 1'b1;
        bus.refill_req = 1'b1;
        if (bus.refill_ack) begin
          if (bus.refill_err) begin
            bus.fault = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        bus.stall     = 1'b1;
        bus.cam_we    = victim_oh;
        bus.cam_wdata = tag_q;
        touch_en      = 1'b1;
        touch_idx     = victim;
        alloc         = full;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
